// File: rtl/mem_port_arbiter_if.sv
// Handshake and memory bus bundle for mem_port_arbiter.
// Latency: none (wires only).
// Backpressure: none here; requesters hold req until the arbiter pulses ack.
// Ports:
//   fetch side : if_req, if_addr -> ; <- if_rdata, if_ack
//   data side  : d_req, d_we, d_addr, d_wdata -> ; <- d_rdata, d_ack
//   memory side: <- mem_cs, mem_we, mem_addr, mem_wdata ; mem_rdata ->
//   status     : <- busy, grant_d
// slave = arbiter view, master = requester/memory (testbench) view.
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          grant_d;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack,
           mem_cs, mem_we, mem_addr, mem_wdata, busy, grant_d
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack,
           mem_cs, mem_we, mem_addr, mem_wdata, busy, grant_d
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync RAM between instruction fetch and data (lw/sw) paths.
// Latency: req sampled in IDLE at cycle t -> mem_cs at t+1 -> ack at t+2+MEM_LAT; one access per MEM_LAT+3 cycles.
// Backpressure: requesters hold req high until their one-cycle ack; the loser simply waits in IDLE.
// Ports:
//   CLK, Reset (async, active low)
//   bus (mem_port_arbiter_if.slave): fetch req/addr/rdata/ack, data req/we/addr/wdata/rdata/ack,
//   memory cs/we/addr/wdata/rdata, busy, grant_d (1 = data owns current/last access).
// Data wins arbitration unless fetch has lost STARVE_MAX consecutive contested decisions.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,   // 1..15
  parameter int STARVE_MAX = 4    // 1..15
) (
  input  logic                    CLK,
  input  logic                    Reset,
  mem_port_arbiter_if.slave       bus
);

  localparam logic [3:0] LAT_LD    = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    wait_cnt, wait_cnt_nxt;
  logic [3:0]    starve_cnt, starve_cnt_nxt;

  // Access latched at the IDLE decision; drives the memory bus from ISSUE
  // until the next decision replaces it.
  logic          grant_q, grant_nxt;
  logic          we_q, we_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [DW-1:0] wdata_q, wdata_nxt;

  logic          capture;
  logic          fetch_wins;

  // Registered outputs.
  logic          mem_cs_q, mem_we_q, busy_q, if_ack_q, d_ack_q;
  logic [DW-1:0] if_rdata_q, d_rdata_q;

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    starve_cnt_nxt = starve_cnt;
    grant_nxt      = grant_q;
    we_nxt         = we_q;
    addr_nxt       = addr_q;
    wdata_nxt      = wdata_q;
    capture        = 1'b0;
    fetch_wins     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          fetch_wins = bus.if_req && (!bus.d_req || (starve_cnt == STARVE_LIM));
          if (fetch_wins) begin
            grant_nxt      = 1'b0;
            we_nxt         = 1'b0;
            addr_nxt       = bus.if_addr;
            starve_cnt_nxt = '0;
          end else begin
            grant_nxt = 1'b1;
            we_nxt    = bus.d_we;
            addr_nxt  = bus.d_addr;
            wdata_nxt = bus.d_wdata;
            // Only a contested loss counts; capped by the fetch_wins check above.
            if (bus.if_req) begin
              starve_cnt_nxt = starve_cnt + 4'd1;
            end
          end
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_nxt = LAT_LD;
        state_nxt    = WAIT;
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        // Counter hits zero at the end of this cycle: this is the
        // ISSUE+MEM_LAT cycle in which mem_rdata is valid.
        if (wait_cnt == 4'd1) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      grant_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
      grant_q    <= grant_nxt;
      we_q       <= we_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
      // Outputs are computed from the next state so they line up with the
      // state they belong to while still coming straight from flops.
      mem_cs_q   <= (state_nxt == ISSUE);
      mem_we_q   <= (state_nxt == ISSUE) && we_nxt;
      busy_q     <= (state_nxt != IDLE);
      if_ack_q   <= (state_nxt == DONE) && !grant_nxt;
      d_ack_q    <= (state_nxt == DONE) && grant_nxt;
      if (capture && !grant_q) begin
        if_rdata_q <= bus.mem_rdata;
      end
      // Stores leave d_rdata untouched.
      if (capture && grant_q && !we_q) begin
        d_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.grant_d   = grant_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.AW(32), .DW(32)) b1 ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) b3 ();

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (b1.slave)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (b3.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // Memory contents; anything outside the read-valid cycle reads as junk so
  // a capture in the wrong cycle shows up as wrong data.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0040: mem_val = 32'h8C01_0004;
      32'h0000_0044: mem_val = 32'h0022_1820;
      32'h0000_0100: mem_val = 32'h1234_5678;
      default:       mem_val = {16'hA5A5, a[15:0]};
    endcase
  endfunction

  logic [31:0] rd1;
  always @(posedge CLK) begin
    rd1 <= (b1.mem_cs && !b1.mem_we) ? mem_val(b1.mem_addr) : 32'hBAD0_0001;
  end
  assign b1.mem_rdata = rd1;

  logic [31:0] rd3 [3];
  always @(posedge CLK) begin
    rd3[0] <= (b3.mem_cs && !b3.mem_we) ? mem_val(b3.mem_addr) : 32'hBAD0_0003;
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign b3.mem_rdata = rd3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
    b3.if_req = 0; b3.if_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;
  endtask

  // Advance until dut1 shows mem_cs, checking ack exclusivity each cycle.
  task automatic wait_cs1(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk({tag, "_ack_excl"}, {31'd0, b1.if_ack & b1.d_ack}, 32'd0);
      if (b1.mem_cs) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_cs_seen"}, {31'd0, seen}, 32'd1);
  endtask

  logic [5:0] grant_pat;

  initial begin
    idle_inputs();
    Reset = 1'b0;
    tick(); tick();
    chk("rst_busy",    {31'd0, b1.busy},    32'd0);
    chk("rst_mem_cs",  {31'd0, b1.mem_cs},  32'd0);
    chk("rst_acks",    {30'd0, b1.if_ack, b1.d_ack}, 32'd0);
    chk("rst_addr",    b1.mem_addr, 32'd0);
    chk("rst_rdata",   b1.if_rdata | b1.d_rdata, 32'd0);
    chk("rst_grant",   {31'd0, b1.grant_d}, 32'd0);
    Reset = 1'b1;
    tick();

    // 1: lone fetch, MEM_LAT=1
    b1.if_req = 1; b1.if_addr = 32'h40;
    tick();
    chk("t1_c1_cs",    {31'd0, b1.mem_cs}, 32'd1);
    chk("t1_c1_we",    {31'd0, b1.mem_we}, 32'd0);
    chk("t1_c1_addr",  b1.mem_addr, 32'h40);
    chk("t1_c1_busy",  {31'd0, b1.busy}, 32'd1);
    chk("t1_c1_dack",  {31'd0, b1.d_ack}, 32'd0);
    tick();
    chk("t1_c2_cs",    {31'd0, b1.mem_cs}, 32'd0);
    chk("t1_c2_acks",  {30'd0, b1.if_ack, b1.d_ack}, 32'd0);
    tick();
    chk("t1_c3_ifack", {31'd0, b1.if_ack}, 32'd1);
    chk("t1_c3_dack",  {31'd0, b1.d_ack}, 32'd0);
    chk("t1_c3_rdata", b1.if_rdata, 32'h8C01_0004);
    b1.if_req = 0;
    tick();
    chk("t1_c4_ifack", {31'd0, b1.if_ack}, 32'd0);
    chk("t1_c4_busy",  {31'd0, b1.busy}, 32'd0);

    // 2: simultaneous fetch and load, data first
    b1.if_req = 1; b1.if_addr = 32'h44;
    b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h100;
    tick();
    chk("t2_c1_cs",    {31'd0, b1.mem_cs}, 32'd1);
    chk("t2_c1_addr",  b1.mem_addr, 32'h100);
    chk("t2_c1_grant", {31'd0, b1.grant_d}, 32'd1);
    tick();
    tick();
    chk("t2_c3_dack",  {31'd0, b1.d_ack}, 32'd1);
    chk("t2_c3_ifack", {31'd0, b1.if_ack}, 32'd0);
    chk("t2_c3_drd",   b1.d_rdata, 32'h1234_5678);
    b1.d_req = 0;
    tick();
    chk("t2_c4_busy",  {31'd0, b1.busy}, 32'd0);
    tick();
    chk("t2_c5_cs",    {31'd0, b1.mem_cs}, 32'd1);
    chk("t2_c5_addr",  b1.mem_addr, 32'h44);
    chk("t2_c5_grant", {31'd0, b1.grant_d}, 32'd0);
    tick();
    tick();
    chk("t2_c7_ifack", {31'd0, b1.if_ack}, 32'd1);
    chk("t2_c7_dack",  {31'd0, b1.d_ack}, 32'd0);
    chk("t2_c7_ifrd",  b1.if_rdata, 32'h0022_1820);
    b1.if_req = 0;
    tick();

    // 3: store; input changes mid-access are ignored
    b1.d_req = 1; b1.d_we = 1; b1.d_addr = 32'h200; b1.d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("t3_c1_cs",    {31'd0, b1.mem_cs}, 32'd1);
    chk("t3_c1_we",    {31'd0, b1.mem_we}, 32'd1);
    chk("t3_c1_addr",  b1.mem_addr, 32'h200);
    chk("t3_c1_wdata", b1.mem_wdata, 32'hDEAD_BEEF);
    b1.d_addr = 32'h300; b1.d_wdata = 32'h0;
    tick();
    chk("t3_c2_cswe",  {30'd0, b1.mem_cs, b1.mem_we}, 32'd0);
    chk("t3_c2_addr",  b1.mem_addr, 32'h200);
    tick();
    chk("t3_c3_dack",  {31'd0, b1.d_ack}, 32'd1);
    chk("t3_c3_drd",   b1.d_rdata, 32'h1234_5678);
    b1.d_req = 0; b1.d_we = 0;
    tick();

    // 4: both held high; four data grants, fetch, then data again
    b1.if_req = 1; b1.if_addr = 32'h80;
    b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h180;
    grant_pat = 6'b101111;   // bit k = expected grant_d of access k
    for (int k = 0; k < 6; k++) begin
      wait_cs1("t4");
      chk("t4_grant", {31'd0, b1.grant_d}, {31'd0, grant_pat[k]});
      chk("t4_addr", b1.mem_addr, grant_pat[k] ? 32'h180 : 32'h80);
    end
    b1.if_req = 0; b1.d_req = 0;
    repeat (4) tick();
    chk("t4_busy",  {31'd0, b1.busy}, 32'd0);
    chk("t4_ifrd",  b1.if_rdata, 32'hA5A5_0080);
    chk("t4_drd",   b1.d_rdata, 32'hA5A5_0180);

    // 5: load with MEM_LAT=3
    b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h100;
    tick();
    chk("t5_c1_cs",   {31'd0, b3.mem_cs}, 32'd1);
    tick();
    chk("t5_c2_dack", {31'd0, b3.d_ack}, 32'd0);
    tick();
    chk("t5_c3_dack", {31'd0, b3.d_ack}, 32'd0);
    tick();
    chk("t5_c4_dack", {31'd0, b3.d_ack}, 32'd0);
    chk("t5_c4_cs",   {31'd0, b3.mem_cs}, 32'd0);
    tick();
    chk("t5_c5_dack", {31'd0, b3.d_ack}, 32'd1);
    chk("t5_c5_drd",  b3.d_rdata, 32'h1234_5678);
    b3.d_req = 0;
    tick();
    chk("t5_c6_dack", {31'd0, b3.d_ack}, 32'd0);
    chk("t5_c6_busy", {31'd0, b3.busy}, 32'd0);

    // 6: async reset in WAIT drops the access
    b1.if_req = 1; b1.if_addr = 32'h40;
    tick();
    chk("t6_c1_cs", {31'd0, b1.mem_cs}, 32'd1);
    tick();
    chk("t6_c2_busy_pre", {31'd0, b1.busy}, 32'd1);
    Reset = 1'b0;
    #1;
    chk("t6_rst_busy",  {31'd0, b1.busy}, 32'd0);
    chk("t6_rst_ifrd",  b1.if_rdata, 32'd0);
    chk("t6_rst_drd",   b1.d_rdata, 32'd0);
    chk("t6_rst_addr",  b1.mem_addr, 32'd0);
    chk("t6_rst_grant", {31'd0, b1.grant_d}, 32'd0);
    b1.if_req = 0;
    tick(); tick();
    Reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_ack", {30'd0, b1.if_ack, b1.busy}, 32'd0);
    end
    b1.if_req = 1; b1.if_addr = 32'h44;
    tick();
    chk("t6_f_cs",   {31'd0, b1.mem_cs}, 32'd1);
    chk("t6_f_addr", b1.mem_addr, 32'h44);
    tick();
    chk("t6_f_c2",   {31'd0, b1.if_ack}, 32'd0);
    tick();
    chk("t6_f_ack",  {31'd0, b1.if_ack}, 32'd1);
    chk("t6_f_rd",   b1.if_rdata, 32'h0022_1820);
    b1.if_req = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
